ft600_tx_framer: RTL and testbench
==================================

// Module: ft600_tx_framer
// PURPOSE
//  Upstream stage of ft600_mode245 TX path: wraps a raw 16-bit sample stream into fixed-length frames
//  (SYNC, header, payload, trailer) and writes them into the ft600_mode245 TX FIFO port.
//  Replaces ad-hoc feeders (count_feeder); host software resynchronises on SYNC and checks trailer.
// PARAMETERS
//  PAYLOAD_LEN  8         payload words per frame, 1..255
//  SYNC_WORD    16'hA55A  first word of every frame
// PORTS
//  clk        in   1   system clock, same domain as ft600_mode245 clk
//  rst        in   1   asynchronous, active-low reset (asserted = 0)
//  in_valid   in   1   upstream sample valid
//  in_data    in   16  upstream sample
//  in_ready   out  1   framer accepts in_data this cycle
//  tx_en      out  1   write strobe into ft600_mode245
//  tx_in      out  16  word written when tx_en=1
//  tx_full    in   1   ft600_mode245 TX FIFO full
//  frame_busy out  1   high from leaving IDLE until trailer written
//  seq        out  8   sequence number of current/next frame
// BEHAVIOUR
//  - Write rule: word transferred on rising clk when tx_en=1; tx_en never high while tx_full=1
//    (tx_en gated combinationally by ~tx_full). Input transfer: in_valid & in_ready.
//  - Reset (rst=0, async): state=IDLE, seq=0, word count=0, checksum=0; tx_en=0, in_ready=0,
//    frame_busy=0, tx_in=16'h0000. Reset mid-frame abandons the frame; no trailer emitted.
//  - FSM:
//    IDLE:    in_ready=0, tx_en=0. in_valid=1 -> SYNC (sample not consumed).
//    SYNC:    tx_in=SYNC_WORD, tx_en=~tx_full; on write -> HDR.
//    HDR:     tx_in={seq, PAYLOAD_LEN[7:0]}, tx_en=~tx_full; on write -> PAYLOAD, cnt=0, chk=init.
//    PAYLOAD: tx_in=in_data, in_ready=~tx_full, tx_en=in_valid&~tx_full (zero-latency pass-through);
//             each transfer: cnt++, chk updated; transfer with cnt==PAYLOAD_LEN-1 -> TRAILER.
//             in_valid low mid-frame: stall indefinitely, no padding, no timeout.
//    TRAILER: tx_in=chk, tx_en=~tx_full; on write -> IDLE, seq<=seq+1 (wraps 255->0).
//  - tx_full held high: current state and tx_in hold stable, nothing lost or duplicated.
//  - Minimum gap: one IDLE cycle between frames; frame length = PAYLOAD_LEN+3 words.
//  - in_data captured only in PAYLOAD; in_ready=0 in every other state.
//  - frame_busy = (state != IDLE).
//  - Checksum (default): chk = sum of payload words mod 2^16, init 16'h0000.
// CONFIGURATION
//  FT600_TX_FRAMER_CRC_EN defined: trailer = CRC-16/CCITT-FALSE over payload (poly 16'h1021,
//   init 16'hFFFF, no reflection, no final XOR), each word fed MSB first, one word per transfer.
//  Undefined: additive checksum above; CRC logic not elaborated. Frame format otherwise identical.
// STRUCTURE
//  - Shared package ft600_pkg: FSM state encoding (IDLE/SYNC/HDR/PAYLOAD/TRAILER), default SYNC
//    word, CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF.
//  - Sub-module ft600_crc16_step (combinational: crc_in[15:0], data[15:0] -> crc_out[15:0]),
//    instantiated only under FT600_TX_FRAMER_CRC_EN.
//  - Top: FSM, 8-bit payload counter, seq register, chk register, output muxing.
// TESTING (bench instantiates framer + ft600_mode245 or a FIFO model; PAYLOAD_LEN=8)
//  1. rst held 0 with in_valid=1 -> tx_en=0, in_ready=0, frame_busy=0, seq=0 throughout.
//  2. Feed 0x0000..0x0007, tx_full=0 -> words A55A,0008,0000..0007,001C; seq then 1; 11 writes.
//  3. tx_full pulsed high 3 cycles during HDR and mid-PAYLOAD -> tx_en=0 while full, tx_in stable,
//     word sequence identical to scenario 2.
//  4. in_valid deasserted after 4 payload words for 10 cycles -> no writes during gap, frame then
//     completes with correct trailer; 300 back-to-back frames -> header seq wraps 0xFF -> 0x00.
//  5. rst asserted after 3 payload words -> outputs to reset values immediately; next frame
//     starts with A55A, header 0x0008 (seq 0).
//  6. FT600_TX_FRAMER_CRC_EN defined, payload 0x0000..0x0007 -> trailer equals bench reference
//     CRC-16/CCITT-FALSE model; all other words as in scenario 2.

Source files
------------

// File: rtl/ft600_pkg.sv
// Shared definitions for the ft600 TX framer: FSM encoding, default SYNC word, CRC-16 constants.
package ft600_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StHdr,
    StPayload,
    StTrailer
  } ft600_state_e;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;
  localparam logic [15:0] CRC16_POLY        = 16'h1021;
  localparam logic [15:0] CRC16_INIT        = 16'hFFFF;

endpackage

// File: rtl/ft600_crc16_step.sv
// One-word CRC-16/CCITT update: folds a 16-bit word into the running CRC, MSB first.
module ft600_crc16_step
  import ft600_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [15:0] data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    logic [15:0] c;
    c = crc_i;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ data_i[i]) begin
        c = {c[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/ft600_tx_framer.sv
// Wraps a 16-bit sample stream into SYNC/header/payload/trailer frames for the ft600 TX FIFO.
// Define FT600_TX_FRAMER_CRC_EN for a CRC-16/CCITT-FALSE trailer instead of the additive checksum.
module ft600_tx_framer
  import ft600_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = 8,
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic [15:0] in_data_i,
  output logic        in_ready_o,
  output logic        tx_en_o,
  output logic [15:0] tx_in_o,
  input  logic        tx_full_i,
  output logic        frame_busy_o,
  output logic [7:0]  seq_o
);

  localparam logic [7:0] LenByte = 8'(PAYLOAD_LEN);
  localparam logic [7:0] LastIdx = 8'(PAYLOAD_LEN - 1);

  ft600_state_e state_q;
  logic [7:0]   seq_q;
  logic [7:0]   cnt_q;
  logic [15:0]  chk_q;
  logic [15:0]  chk_upd;
  logic [15:0]  chk_init;

`ifdef FT600_TX_FRAMER_CRC_EN
  assign chk_init = CRC16_INIT;

  ft600_crc16_step u_crc16_step (
    .crc_i  (chk_q),
    .data_i (in_data_i),
    .crc_o  (chk_upd)
  );
`else
  assign chk_init = 16'h0000;
  assign chk_upd  = chk_q + in_data_i;
`endif

  // Outputs decode from the registered state; tx_en is gated by tx_full in the same cycle.
  always_comb begin
    tx_en_o    = 1'b0;
    in_ready_o = 1'b0;
    tx_in_o    = 16'h0000;
    unique case (state_q)
      StSync: begin
        tx_in_o = SYNC_WORD;
        tx_en_o = ~tx_full_i;
      end
      StHdr: begin
        tx_in_o = {seq_q, LenByte};
        tx_en_o = ~tx_full_i;
      end
      StPayload: begin
        tx_in_o    = in_data_i;
        in_ready_o = ~tx_full_i;
        tx_en_o    = in_valid_i & ~tx_full_i;
      end
      StTrailer: begin
        tx_in_o = chk_q;
        tx_en_o = ~tx_full_i;
      end
      default: ;
    endcase
  end

  assign frame_busy_o = (state_q != StIdle);
  assign seq_o        = seq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      seq_q   <= 8'd0;
      cnt_q   <= 8'd0;
      chk_q   <= 16'h0000;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) state_q <= StSync;
        end
        StSync: begin
          if (tx_en_o) state_q <= StHdr;
        end
        StHdr: begin
          if (tx_en_o) begin
            state_q <= StPayload;
            cnt_q   <= 8'd0;
            chk_q   <= chk_init;
          end
        end
        StPayload: begin
          // In this state tx_en coincides exactly with an input transfer.
          if (tx_en_o) begin
            cnt_q <= cnt_q + 8'd1;
            chk_q <= chk_upd;
            if (cnt_q == LastIdx) state_q <= StTrailer;
          end
        end
        StTrailer: begin
          if (tx_en_o) begin
            state_q <= StIdle;
            seq_q   <= seq_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ft600_tx_framer.sv
// Randomized self-checking bench for ft600_tx_framer against a frame-level reference model.
module tb_ft600_tx_framer;

  localparam int PLEN = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [15:0] in_data_i = 16'h0000;
  logic        in_ready_o;
  logic        tx_en_o;
  logic [15:0] tx_in_o;
  logic        tx_full_i = 1'b0;
  logic        frame_busy_o;
  logic [7:0]  seq_o;

  ft600_tx_framer #(
    .PAYLOAD_LEN (PLEN),
    .SYNC_WORD   (16'hA55A)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .tx_en_o      (tx_en_o),
    .tx_in_o      (tx_in_o),
    .tx_full_i    (tx_full_i),
    .frame_busy_o (frame_busy_o),
    .seq_o        (seq_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] src_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  model_seq = 8'd0;

  int unsigned valid_pct = 100;
  int unsigned full_pct  = 0;
  int unsigned full_burst = 0;
  logic        prev_full = 1'b0;
  logic        prev_busy = 1'b0;
  logic [15:0] prev_tx   = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] trailer_ref(input logic [15:0] p[PLEN]);
    logic [15:0] r;
`ifdef FT600_TX_FRAMER_CRC_EN
    logic fb;
    r = 16'hFFFF;
    for (int w = 0; w < PLEN; w++) begin
      for (int b = 15; b >= 0; b--) begin
        fb = r[15] ^ p[w][b];
        r  = (r << 1) ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
`else
    int unsigned s;
    s = 0;
    for (int w = 0; w < PLEN; w++) s += p[w];
    r = 16'(s % 65536);
`endif
    return r;
  endfunction

  // Expected frame goes into exp_q; the first n_src payload words are offered upstream.
  task automatic queue_frame(input logic [15:0] p[PLEN], input int n_src);
    exp_q.push_back(16'hA55A);
    exp_q.push_back({model_seq, 8'(PLEN)});
    for (int i = 0; i < PLEN; i++) exp_q.push_back(p[i]);
    exp_q.push_back(trailer_ref(p));
    for (int i = 0; i < n_src; i++) src_q.push_back(p[i]);
    model_seq = model_seq + 8'd1;
  endtask

  task automatic drive_inputs();
    if (full_burst > 0) begin
      full_burst--;
      tx_full_i = 1'b1;
    end else if ($urandom_range(99) < full_pct) begin
      full_burst = 2;
      tx_full_i  = 1'b1;
    end else begin
      tx_full_i = 1'b0;
    end
    in_valid_i = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
    in_data_i  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
  endtask

  task automatic step();
    logic xfer;
    @(negedge clk_i);
    if (tx_full_i) check("en_gate", {31'd0, tx_en_o}, 32'd0);
    if (!frame_busy_o) check("idle_rdy", {31'd0, in_ready_o}, 32'd0);
    if (tx_full_i && prev_full && frame_busy_o && prev_busy)
      check("hold", {16'd0, tx_in_o}, {16'd0, prev_tx});
    if (tx_en_o) begin
      if (exp_q.size() == 0) check("exp_avail", 32'(exp_q.size()), 32'd1);
      else check("word", {16'd0, tx_in_o}, {16'd0, exp_q.pop_front()});
    end
    xfer      = in_valid_i & in_ready_o;
    prev_full = tx_full_i;
    prev_busy = frame_busy_o;
    prev_tx   = tx_in_o;
    @(posedge clk_i);
    #1;
    if (xfer && src_q.size() > 0) void'(src_q.pop_front());
    drive_inputs();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    src_q.delete();
  endtask

  initial begin
    logic [15:0] p[PLEN];
    int n;

    // Reset held with in_valid high: everything quiet.
    in_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check("rst_en", {31'd0, tx_en_o}, 32'd0);
      check("rst_rdy", {31'd0, in_ready_o}, 32'd0);
      check("rst_busy", {31'd0, frame_busy_o}, 32'd0);
      check("rst_seq", {24'd0, seq_o}, 32'd0);
    end
    @(posedge clk_i);
    #1;
    rst_ni     = 1'b1;
    in_valid_i = 1'b0;

    // Incrementing payload, no backpressure.
    for (int i = 0; i < PLEN; i++) p[i] = 16'(i);
    queue_frame(p, PLEN);
    drive_inputs();
    drain("basic", 100);
    step();
    check("seq_after", {24'd0, seq_o}, 32'd1);
`ifndef FT600_TX_FRAMER_CRC_EN
    check("sum_ref", {16'd0, trailer_ref(p)}, 32'h001C);
`endif

    // Same payload under bursty tx_full.
    full_pct = 25;
    queue_frame(p, PLEN);
    drain("full", 400);

    // Explicit 10-cycle upstream gap after 4 payload words.
    full_pct = 0;
    for (int i = 0; i < PLEN; i++) p[i] = 16'($urandom_range(1, 16'hFFFF));
    queue_frame(p, 4);
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > PLEN - 4 + 1) && n < 100) begin
      step();
      n++;
    end
    for (int c = 0; c < 10; c++) step();
    check("gap_nowr", 32'(exp_q.size()), 32'(PLEN - 4 + 1));
    for (int i = 4; i < PLEN; i++) src_q.push_back(p[i]);
    drain("gap", 100);

    // 300 back-to-back random frames with random stalls; header seq wraps.
    valid_pct = 80;
    full_pct  = 10;
    for (int f = 0; f < 300; f++) begin
      for (int i = 0; i < PLEN; i++) p[i] = 16'($urandom);
      queue_frame(p, PLEN);
    end
    drain("b2b", 20000);
    check("seq_wrap", {24'd0, seq_o}, {24'd0, model_seq});

    // Async reset after 3 payload words abandons the frame.
    valid_pct = 100;
    full_pct  = 0;
    for (int i = 0; i < PLEN; i++) p[i] = 16'($urandom);
    queue_frame(p, PLEN);
    n = 0;
    while (exp_q.size() > PLEN + 3 - 5 && n < 100) begin
      step();
      n++;
    end
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_en", {31'd0, tx_en_o}, 32'd0);
    check("arst_rdy", {31'd0, in_ready_o}, 32'd0);
    check("arst_busy", {31'd0, frame_busy_o}, 32'd0);
    check("arst_tx", {16'd0, tx_in_o}, 32'd0);
    check("arst_seq", {24'd0, seq_o}, 32'd0);
    exp_q.delete();
    src_q.delete();
    model_seq  = 8'd0;
    in_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < PLEN; i++) p[i] = 16'($urandom);
    queue_frame(p, PLEN);
    drive_inputs();
    drain("post_rst", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
